// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor: measures a divided PLL clock against clkin over a gate
// window and derives a registered lock / lost indication from the counts.
module pll_clk_monitor #(
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 16,
    parameter int EXP_COUNT   = 15625,
    parameter int TOL         = 16,
    parameter int LOCK_WINS   = 4
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             mon_tgl,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);

    localparam int GTW = $clog2(GATE_CYCLES);
    localparam int GDW = $clog2(LOCK_WINS + 1);
    localparam int LO  = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
    localparam int HI  = EXP_COUNT + TOL;

    localparam logic [GTW-1:0]   GATE_LAST = GTW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [GDW-1:0]   WINS      = GDW'(LOCK_WINS);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             mon_rise;
    logic [GTW-1:0]   gate;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] total;
    logic             term;
    logic             win_ok;
    state_t           state;
    state_t           state_n;
    logic [GDW-1:0]   good;
    logic [GDW-1:0]   good_n;
    logic             lost_n;

    assign mon_rise = sync2 & ~prev;
    assign term     = enable && (gate == GATE_LAST);

    // Window total includes an edge detected in the terminal cycle; saturates.
    assign total = (mon_rise && (edge_cnt != CNT_MAX))
                 ? edge_cnt + CNT_W'(1) : edge_cnt;

    // Unsigned compare, zero-extended so EXP_COUNT+TOL cannot overflow.
    assign win_ok = (32'(total) >= 32'(LO)) && (32'(total) <= 32'(HI));

    assign locked = (state == LOCKED);

    // Synchronize the asynchronous toggle and keep one extra stage for edges.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= mon_tgl;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Gate window counter and per-window edge accumulator.
    always_ff @(posedge clkin) begin
        if (reset || !enable) begin
            gate     <= '0;
            edge_cnt <= '0;
        end else if (term) begin
            gate     <= '0;
            edge_cnt <= '0;
        end else begin
            gate     <= gate + GTW'(1);
            edge_cnt <= total;
        end
    end

    // Publish the window result; count and in_range hold between windows.
    always_ff @(posedge clkin) begin
        if (reset) begin
            count       <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
        end else begin
            count_valid <= term;
            if (term) begin
                count    <= total;
                in_range <= win_ok;
            end
        end
    end

    // Lock state, good-window count and the registered lost pulse.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state <= UNLOCKED;
            good  <= '0;
            lost  <= 1'b0;
        end else begin
            state <= state_n;
            good  <= good_n;
            lost  <= lost_n;
        end
    end

    // Lock decisions are taken only at the end of a window.
    always_comb begin
        state_n = state;
        good_n  = good;
        lost_n  = 1'b0;
        if (!enable) begin
            state_n = UNLOCKED;
            good_n  = '0;
        end else if (term) begin
            unique case (state)
                UNLOCKED: begin
                    if (win_ok) begin
                        good_n  = GDW'(1);
                        state_n = (LOCK_WINS == 1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (win_ok) begin
                        good_n = good + GDW'(1);
                        if (good_n == WINS) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        good_n  = '0;
                        state_n = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!win_ok) begin
                        good_n  = '0;
                        state_n = UNLOCKED;
                        lost_n  = 1'b1;
                    end
                end
                default: begin
                    good_n  = '0;
                    state_n = UNLOCKED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_clk_monitor.sv
// tb_pll_clk_monitor: scoreboard bench; per-window expectations are queued
// as stimulus is applied and retired on each count_valid.
module tb_pll_clk_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       mon_tgl = 1'b0;
    logic       en_s = 1'b0;
    logic       mon_s = 1'b0;

    logic [7:0] count;
    logic       count_valid;
    logic       in_range;
    logic       locked;
    logic       lost;

    logic [3:0] count_s;
    logic       cv_s;
    logic       in_range_s;
    logic       locked_s;
    logic       lost_s;

    typedef struct {
        int lo;
        int hi;
        bit inr;
        bit lck;
        bit lst;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_fail = 0;
    int per = 4;
    int ph = 0;
    int ph_s = 0;
    int cyc = 0;
    int last_cv = 0;
    int n_cv_s = 0;
    bit restart = 1'b1;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    pll_clk_monitor #(
        .GATE_CYCLES(100),
        .CNT_W      (8),
        .EXP_COUNT  (25),
        .TOL        (2),
        .LOCK_WINS  (3)
    ) dut (
        .clkin      (clk),
        .reset      (reset),
        .enable     (enable),
        .mon_tgl    (mon_tgl),
        .count      (count),
        .count_valid(count_valid),
        .in_range   (in_range),
        .locked     (locked),
        .lost       (lost)
    );

    pll_clk_monitor #(
        .GATE_CYCLES(100),
        .CNT_W      (4),
        .EXP_COUNT  (25),
        .TOL        (2),
        .LOCK_WINS  (3)
    ) dut_s (
        .clkin      (clk),
        .reset      (reset),
        .enable     (en_s),
        .mon_tgl    (mon_s),
        .count      (count_s),
        .count_valid(cv_s),
        .in_range   (in_range_s),
        .locked     (locked_s),
        .lost       (lost_s)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    // Divided-clock generators, driven away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            ph      = (ph + 1 >= per) ? 0 : ph + 1;
            mon_tgl = (ph < per / 2);
            ph_s    = (ph_s + 1 >= 3) ? 0 : ph_s + 1;
            mon_s   = (ph_s == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Retire scoreboard entries whenever a window result appears.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (count_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_count_valid", count_valid, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.lo == mon_e.hi)
                            check("count", count, mon_e.lo);
                        else
                            check("count_window",
                                  (count >= mon_e.lo && count <= mon_e.hi), 1);
                        check("in_range", in_range, mon_e.inr);
                        check("locked", locked, mon_e.lck);
                        check("lost", lost, mon_e.lst);
                    end
                    if (!restart)
                        check("window_period", cyc - last_cv, 100);
                    restart = 1'b0;
                    last_cv = cyc;
                end else begin
                    check("lost_without_cv", lost, 0);
                end
                if (cv_s === 1'b1) begin
                    n_cv_s++;
                    check("sat_count", count_s, 15);
                    check("sat_in_range", in_range_s, 0);
                    check("sat_locked", locked_s, 0);
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic win(input int p, input int lo, input int hi,
                       input bit inr, input bit lck, input bit lst);
        exp_t e;
        per = p;
        e = '{lo, hi, inr, lck, lst};
        sb.push_back(e);
        drain(130);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        mon_on = 1'b1;
        reset  = 1'b0;

        repeat (500) @(negedge clk);
        check("off_count", count, 0);
        check("off_in_range", in_range, 0);
        check("off_locked", locked, 0);

        enable  = 1'b1;
        en_s    = 1'b1;
        restart = 1'b1;
        win(4, 24, 26, 1, 0, 0);
        win(4, 25, 25, 1, 0, 0);
        win(4, 25, 25, 1, 1, 0);

        win(5, 19, 21, 0, 0, 1);
        win(4, 24, 26, 1, 0, 0);
        win(4, 25, 25, 1, 0, 0);
        win(4, 25, 25, 1, 1, 0);

        win(5, 19, 21, 0, 0, 1);
        win(4, 24, 26, 1, 0, 0);
        win(5, 19, 21, 0, 0, 0);
        win(4, 24, 26, 1, 0, 0);
        win(5, 19, 21, 0, 0, 0);

        win(4, 24, 26, 1, 0, 0);
        win(4, 25, 25, 1, 0, 0);
        win(4, 25, 25, 1, 1, 0);

        check("sat_windows", n_cv_s, 15);
        en_s = 1'b0;

        repeat (30) @(negedge clk);
        check("locked_before_disable", locked, 1);
        enable  = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        check("dis_locked", locked, 0);
        check("dis_lost", lost, 0);
        check("dis_count_valid", count_valid, 0);
        check("dis_count_hold", count, 25);
        check("dis_in_range_hold", in_range, 1);
        repeat (150) @(negedge clk);
        check("dis_count_hold_late", count, 25);
        check("dis_locked_late", locked, 0);

        enable  = 1'b1;
        restart = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_count", count, 0);
        check("mid_rst_count_valid", count_valid, 0);
        check("mid_rst_in_range", in_range, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_lost", lost, 0);
        reset   = 1'b0;
        restart = 1'b1;
        win(4, 24, 26, 1, 0, 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
